// File: rtl/sram_bus_adapter.sv
// Byte-addressed valid/ready request bus to a single-port word SRAM with per-byte write mask.
// Latency accept->rsp_valid_o: error 1, write 2, read 3 cycles; one request in flight at a time.
// Backpressure: req_ready_o high only in IDLE; the response is held until rsp_ready_i.
// Optional feature macro SRAM_RD_SIGNEXT_EN: adds req_signed_i, sign-extends sub-word reads.
// Ports: clk_i/rst_ni clock and async active-low reset; req_* request channel (we, byte addr,
//   size 0..3 = byte..doubleword, LSB-justified wdata); rsp_* response channel (rdata, err);
//   sram_* macro side (csb/web active low, word addr, byte wmask, din, dout one cycle after read).
module sram_bus_adapter #(
   parameter  int WIDTH  = 32,
   parameter  int DEPTH  = 256,
   localparam int AWIDTH = $clog2(DEPTH * WIDTH / 8),
   localparam int LWIDTH = (WIDTH == 8) ? 1 : $clog2(WIDTH / 8),
   localparam int WAW    = $clog2(DEPTH)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic [AWIDTH-1:0]   req_addr_i,
   input  logic [1:0]          req_size_i,
   input  logic [WIDTH-1:0]    req_wdata_i,
`ifdef SRAM_RD_SIGNEXT_EN
   input  logic                req_signed_i,
`endif
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [WIDTH-1:0]    rsp_rdata_o,
   output logic                rsp_err_o,
   output logic                sram_csb_o,
   output logic                sram_web_o,
   output logic [WAW-1:0]      sram_addr_o,
   output logic [WIDTH/8-1:0]  sram_wmask_o,
   output logic [WIDTH-1:0]    sram_din_o,
   input  logic [WIDTH-1:0]    sram_dout_i
);

   localparam int         NB       = WIDTH / 8;
   localparam int         OFFB     = $clog2(NB);
   localparam logic [1:0] MAX_SIZE = 2'(OFFB);

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RSP} state_t;
   state_t state;

   logic [LWIDTH-1:0] off, off_q;
   logic [3:0]        nbm1, nbm1_q;   // transfer bytes minus one
   logic              req_err;
   logic [NB-1:0]     wmask_n;
   logic [WIDTH-1:0]  din_n;
   logic [WIDTH-1:0]  rd_shift;
   logic [WIDTH-1:0]  rd_ext;
   logic              sign_bit;
   logic              sext_en;

   // A byte-wide SRAM has no lane offset; the single LWIDTH bit is forced to zero.
   assign off = req_addr_i[LWIDTH-1:0] & LWIDTH'(NB - 1);

   always_comb begin
      case (req_size_i)
         2'd0:    nbm1 = 4'd0;
         2'd1:    nbm1 = 4'd1;
         2'd2:    nbm1 = 4'd3;
         default: nbm1 = 4'd7;
      endcase
   end

   assign req_err = (req_size_i > MAX_SIZE) | ((4'(off) & nbm1) != 4'd0);

   // Lane mask covers [off, off+nbm1]; write data is the low transfer replicated on every lane.
   always_comb begin
      wmask_n = '0;
      din_n   = '0;
      for (int i = 0; i < NB; i++) begin
         wmask_n[i] = req_we_i && (4'(i) >= 4'(off)) && (4'(i) <= 4'(off) + nbm1);
         for (int j = 0; j < NB; j++) begin
            if (4'(j) == (4'(i) & nbm1)) begin
               din_n[8*i +: 8] = req_wdata_i[8*j +: 8];
            end
         end
      end
   end

   assign rd_shift = sram_dout_i >> {off_q, 3'b000};

`ifdef SRAM_RD_SIGNEXT_EN
   logic signed_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         signed_q <= 1'b0;
      end else if (state == IDLE && req_valid_i) begin
         signed_q <= req_signed_i;
      end
   end

   // Full-word reads have nothing to extend.
   assign sext_en = signed_q && (nbm1_q < 4'(NB - 1));
`else
   assign sext_en = 1'b0;
`endif

   always_comb begin
      rd_ext   = '0;
      sign_bit = 1'b0;
      for (int j = 0; j < NB; j++) begin
         if (4'(j) == nbm1_q) sign_bit = rd_shift[8*j+7];
      end
      for (int j = 0; j < NB; j++) begin
         if (4'(j) <= nbm1_q)  rd_ext[8*j +: 8] = rd_shift[8*j +: 8];
         else if (sext_en)     rd_ext[8*j +: 8] = {8{sign_bit}};
      end
   end

   assign req_ready_o = rst_ni & (state == IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         sram_csb_o   <= 1'b1;
         sram_web_o   <= 1'b1;
         sram_addr_o  <= '0;
         sram_wmask_o <= '0;
         sram_din_o   <= '0;
         rsp_valid_o  <= 1'b0;
         rsp_rdata_o  <= '0;
         rsp_err_o    <= 1'b0;
         off_q        <= '0;
         nbm1_q       <= '0;
      end else begin
         // Strobe is a single-cycle pulse; addr/din keep their last value.
         sram_csb_o   <= 1'b1;
         sram_web_o   <= 1'b1;
         sram_wmask_o <= '0;
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  off_q  <= off;
                  nbm1_q <= nbm1;
                  if (req_err) begin
                     rsp_valid_o <= 1'b1;
                     rsp_err_o   <= 1'b1;
                     rsp_rdata_o <= '0;
                     state       <= RSP;
                  end else begin
                     sram_csb_o   <= 1'b0;
                     sram_web_o   <= ~req_we_i;
                     sram_addr_o  <= WAW'(req_addr_i >> OFFB);
                     sram_wmask_o <= wmask_n;
                     sram_din_o   <= din_n;
                     state        <= req_we_i ? WR_ISSUE : RD_ISSUE;
                  end
               end
            end
            RD_ISSUE: state <= RD_WAIT;
            RD_WAIT: begin
               rsp_rdata_o <= rd_ext;
               rsp_err_o   <= 1'b0;
               rsp_valid_o <= 1'b1;
               state       <= RSP;
            end
            WR_ISSUE: begin
               rsp_rdata_o <= '0;
               rsp_err_o   <= 1'b0;
               rsp_valid_o <= 1'b1;
               state       <= RSP;
            end
            RSP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_bus_adapter.sv
// Bench for sram_bus_adapter: byte-array reference memory, response and strobe scoreboards.
// Stimulus issues requests and pushes expectations; a negedge monitor pops and compares.
// Response-ready is randomised or forced per phase to exercise backpressure.
module tb_sram_bus_adapter;
   localparam int WIDTH = 32;
   localparam int DEPTH = 256;
   localparam int AW    = 10;
   localparam int WAW   = 8;
   localparam int NB    = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_we = 1'b0;
   logic [AW-1:0]    req_addr = '0;
   logic [1:0]       req_size = '0;
   logic [31:0]      req_wdata = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [31:0]      rsp_rdata;
   logic             rsp_err;
   logic             sram_csb;
   logic             sram_web;
   logic [WAW-1:0]   sram_addr;
   logic [NB-1:0]    sram_wmask;
   logic [31:0]      sram_din;
   logic [31:0]      sram_dout = '0;
`ifdef SRAM_RD_SIGNEXT_EN
   logic             req_signed = 1'b0;
`endif

   sram_bus_adapter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_we_i     (req_we),
      .req_addr_i   (req_addr),
      .req_size_i   (req_size),
      .req_wdata_i  (req_wdata),
`ifdef SRAM_RD_SIGNEXT_EN
      .req_signed_i (req_signed),
`endif
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_rdata_o  (rsp_rdata),
      .rsp_err_o    (rsp_err),
      .sram_csb_o   (sram_csb),
      .sram_web_o   (sram_web),
      .sram_addr_o  (sram_addr),
      .sram_wmask_o (sram_wmask),
      .sram_din_o   (sram_din),
      .sram_dout_i  (sram_dout)
   );

   always #5 clk = ~clk;

   int cnt = 0;
   always @(posedge clk) cnt <= cnt + 1;

   // SRAM macro model: masked write, read data one cycle after the strobe.
   bit [31:0] sram_mem [DEPTH];
   always @(posedge clk) begin
      if (sram_csb === 1'b0) begin
         if (sram_web === 1'b0) begin
            for (int b = 0; b < NB; b++)
               if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] = sram_din[8*b +: 8];
         end else begin
            sram_dout <= sram_mem[sram_addr];
         end
      end
   end

   typedef struct { logic [31:0] rdata; logic err; int acc; int lat; } rsp_t;
   typedef struct { int acc; logic [WAW-1:0] addr; logic web; logic [NB-1:0] wmask; logic [31:0] din; } stb_t;

   rsp_t rq[$];
   stb_t sq[$];
   byte unsigned ref_mem [1024];

   int n_pass = 0;
   int n_chk  = 0;
   int acc_cnt = 0;
   int last_hs = -10;
   int rdy_mode = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference behaviour computed from the byte-addressed view of memory.
   task automatic push_model();
      int   nb;
      int   off;
      rsp_t r;
      stb_t s;
      nb  = 1 << req_size;
      off = int'(req_addr) % NB;
      r.acc   = cnt;
      r.rdata = '0;
      r.err   = (nb > NB) || ((int'(req_addr) % nb) != 0);
      if (r.err) begin
         r.lat = 1;
      end else begin
         r.lat   = req_we ? 2 : 3;
         s.acc   = cnt;
         s.addr  = WAW'(int'(req_addr) / NB);
         s.web   = !req_we;
         s.wmask = '0;
         s.din   = '0;
         for (int b = 0; b < nb; b++) begin
            if (req_we) begin
               ref_mem[int'(req_addr) + b] = req_wdata[8*b +: 8];
               s.wmask[off + b] = 1'b1;
            end else begin
               r.rdata[8*b +: 8] = ref_mem[int'(req_addr) + b];
            end
         end
         for (int i = 0; i < NB; i++) s.din[8*i +: 8] = req_wdata[8*(i % nb) +: 8];
         sq.push_back(s);
      end
      rq.push_back(r);
   endtask

   task automatic wait_accept();
      int w = 0;
      while (req_ready !== 1'b1 && w < 200) begin
         w++;
         @(negedge clk);
      end
      if (req_ready !== 1'b1) begin
         check("accept_timeout", req_ready, 1);
         req_valid = 1'b0;
      end else begin
         push_model();
         acc_cnt = cnt;
         @(posedge clk);
         #1 req_valid = 1'b0;
      end
   endtask

   task automatic send(input logic we, input logic [AW-1:0] a, input logic [1:0] sz, input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_size  = sz;
      req_wdata = wd;
      wait_accept();
   endtask

   task automatic drain();
      int w = 0;
      while ((rq.size() != 0 || sq.size() != 0) && w < 300) begin
         w++;
         @(negedge clk);
      end
      check("drain_rsp_queue", rq.size(), 0);
      check("drain_strobe_queue", sq.size(), 0);
   endtask

   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       rsp_ready = ($urandom_range(0, 3) != 0);
         1:       rsp_ready = 1'b0;
         default: rsp_ready = 1'b1;
      endcase
   end

   // Monitor: strobes, responses, latency and hold-under-backpressure.
   logic        pend = 1'b0;
   logic [31:0] prev_rdata = '0;
   logic        prev_err = 1'b0;
   rsp_t        mon_e;
   stb_t        mon_s;
   always @(negedge clk) begin
      if (!rst_n) begin
         pend = 1'b0;
      end else begin
         if (sram_csb === 1'b0) begin
            if (sq.size() == 0) begin
               check("unexpected_strobe", sram_csb, 1);
            end else begin
               mon_s = sq.pop_front();
               check("strobe_cycle", cnt, mon_s.acc + 1);
               check("strobe_addr", sram_addr, mon_s.addr);
               check("strobe_web", sram_web, mon_s.web);
               check("strobe_wmask", sram_wmask, mon_s.wmask);
               if (!mon_s.web) check("strobe_din", sram_din, mon_s.din);
            end
         end else begin
            check("idle_web", sram_web, 1);
            check("idle_wmask", sram_wmask, 0);
         end
         if (rsp_valid === 1'b1) begin
            check("req_ready_in_rsp", req_ready, 0);
            if (pend) begin
               check("hold_rdata", rsp_rdata, prev_rdata);
               check("hold_err", rsp_err, prev_err);
            end else if (rq.size() == 0) begin
               check("unexpected_rsp", rsp_valid, 0);
            end else begin
               check("rsp_latency", cnt - rq[0].acc, rq[0].lat);
            end
            if (rsp_ready && rq.size() > 0) begin
               mon_e = rq.pop_front();
               check("rsp_rdata", rsp_rdata, mon_e.rdata);
               check("rsp_err", rsp_err, mon_e.err);
               last_hs = cnt;
            end
            pend       = !rsp_ready;
            prev_rdata = rsp_rdata;
            prev_err   = rsp_err;
         end else begin
            pend = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      int               w;
      logic [1:0]       sz;
      logic [AW-1:0]    a;

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_csb", sram_csb, 1);
      check("rst_web", sram_web, 1);
      check("rst_addr", sram_addr, 0);
      check("rst_wmask", sram_wmask, 0);
      check("rst_din", sram_din, 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", req_ready, 1);

      // Directed: word write, byte write, halfword read, misaligned and oversize errors.
      rdy_mode = 2;
      send(1'b1, 10'h010, 2'd2, 32'hDEADBEEF);
      send(1'b1, 10'h013, 2'd0, 32'h000000A5);
      send(1'b0, 10'h012, 2'd1, 32'h0);
      send(1'b0, 10'h011, 2'd1, 32'h0);
      send(1'b0, 10'h010, 2'd3, 32'h0);
      drain();

      // Backpressure: response held for several cycles, request waits until IDLE.
      rdy_mode = 1;
      send(1'b0, 10'h010, 2'd2, 32'h0);
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (rsp_valid !== 1'b1 && w < 20);
      check("stall_rsp_seen", rsp_valid, 1);
      repeat (5) @(negedge clk);
      check("stall_rsp_valid", rsp_valid, 1);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 10'h013;
      req_size  = 2'd0;
      check("stall_no_accept", req_ready, 0);
      rdy_mode = 2;
      wait_accept();
      check("accept_after_release", acc_cnt, last_hs + 1);
      drain();

      // Reset while waiting for read data: response dropped.
      send(1'b0, 10'h014, 2'd2, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rwait_rst_csb", sram_csb, 1);
      check("rwait_rst_rsp_valid", rsp_valid, 0);
      check("rwait_rst_req_ready", req_ready, 0);
      rq.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("no_rsp_after_reset", rsp_valid, 0);

      // Reset during the strobe cycle: chip select released asynchronously.
      send(1'b0, 10'h018, 2'd2, 32'h0);
      @(negedge clk);
      check("strobe_before_rst", sram_csb, 0);
      #2 rst_n = 1'b0;
      #1;
      check("strobe_rst_csb", sram_csb, 1);
      check("strobe_rst_rsp_valid", rsp_valid, 0);
      rq.delete();
      sq.delete();
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("no_rsp_after_reset2", rsp_valid, 0);

      // Randomised traffic with random response backpressure.
      rdy_mode = 0;
      for (int i = 0; i < 300; i++) begin
         sz = 2'($urandom_range(0, 3));
         a  = AW'($urandom);
         if ($urandom_range(0, 9) < 7) a = (a >> sz) << sz;
         send(1'($urandom), a, sz, $urandom);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
